// File: rtl/hdmi_text_pixels.sv
// hdmi_text_pixels: character-cell text renderer for a 1024x600 active raster.
// Turns upstream timing into character RAM / font ROM lookups and emits one
// RGB pixel per clock, three cycles behind the timing inputs.
//
// Optional feature macro: HDMI_TEXT_CURSOR_EN (adds a blinking block cursor).
//
// Ports:
//   clk, reset_low                 pixel clock, async active-low reset
//   active, h_sync, v_sync         registered upstream timing
//   h_start, v_start               first-pixel-of-line / first-line-of-frame pulses
//   char_addr / char_data          character RAM port {row,col} / {inverse,glyph}
//   font_addr / font_data          font ROM port {glyph,scanline} / 8 pixels, MSB left
//   cursor_col, cursor_row         cursor cell (HDMI_TEXT_CURSOR_EN only)
//   out_active, out_h_sync,
//   out_v_sync, out_rgb            timing delayed 3 cycles plus pixel colour
module hdmi_text_pixels #(
  parameter int unsigned COLUMNS      = 128,
  parameter int unsigned ROWS         = 40,
  parameter int unsigned GLYPH_HEIGHT = 15,
  parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB       = 24'h000000
) (
  input  logic        clk,
  input  logic        reset_low,
  input  logic        active,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        h_start,
  input  logic        v_start,
  output logic [12:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
`ifdef HDMI_TEXT_CURSOR_EN
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row,
`endif
  output logic        out_active,
  output logic        out_h_sync,
  output logic        out_v_sync,
  output logic [23:0] out_rgb
);

  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 6;
  localparam int unsigned SCAN_W = 4;
  localparam int unsigned PIX_W  = 3;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLUMNS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(GLYPH_HEIGHT - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(7);

  // Stage 0 counters
  logic [COL_W-1:0]  col_q, col_d, col_cur;
  logic [PIX_W-1:0]  pix_q, pix_d, pix_cur;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              armed_q;
  logic              line_act;

  // Stage 1 / stage 2 pipeline
  logic              s1_act_q, s1_hs_q, s1_vs_q;
  logic [SCAN_W-1:0] s1_scan_q;
  logic [PIX_W-1:0]  s1_pix_q;
  logic              s2_act_q, s2_hs_q, s2_vs_q;
  logic [PIX_W-1:0]  s2_pix_q;
  logic              s2_inv_q;
  logic              cursor_c;
  logic              pixel_on;

  // Stage 0: current position for this cycle's address and next counter state
  always_comb begin
    col_cur = h_start ? '0 : col_q;
    pix_cur = h_start ? '0 : pix_q;
    scan_d  = scan_q;
    row_d   = row_q;
    if (v_start) begin
      scan_d = '0;
      row_d  = '0;
    end else if (h_start) begin
      if (scan_q == SCAN_LAST) begin
        scan_d = '0;
        if (row_q != ROW_LAST) row_d = row_q + 1'b1;
      end else begin
        scan_d = scan_q + 1'b1;
      end
    end
    col_d = col_cur;
    pix_d = pix_cur;
    if (active) begin
      pix_d = pix_cur + 1'b1;
      if (pix_cur == PIX_LAST && col_cur != COL_LAST) col_d = col_cur + 1'b1;
    end
  end

  // After reset, suppress output until a line is properly started.
  assign line_act = active & (armed_q | h_start);

  // Address outputs are combinational by construction; forced to 0 in reset.
  assign char_addr = reset_low ? {row_d, col_cur} : '0;
  assign font_addr = reset_low ? {char_data[6:0], s1_scan_q} : '0;

`ifdef HDMI_TEXT_CURSOR_EN
  logic [4:0] frame_q, frame_cur;
  logic       started_q;
  logic       s1_cur_q, s2_cur_q;

  // First v_start after reset opens frame 0; later ones advance the count.
  assign frame_cur = (v_start && started_q) ? frame_q + 1'b1 : frame_q;

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      frame_q   <= '0;
      started_q <= 1'b0;
      s1_cur_q  <= 1'b0;
      s2_cur_q  <= 1'b0;
    end else begin
      if (v_start) started_q <= 1'b1;
      frame_q  <= frame_cur;
      s1_cur_q <= (col_cur == cursor_col) && (row_d == cursor_row) && !frame_cur[4];
      s2_cur_q <= s1_cur_q;
    end
  end

  assign cursor_c = s2_cur_q;
`else
  assign cursor_c = 1'b0;
`endif

  // Stage 2: pick this pixel's font bit, apply inverse video and cursor
  assign pixel_on = font_data[PIX_LAST - s2_pix_q] ^ s2_inv_q ^ cursor_c;

  // Counters and the three pipeline stages
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      col_q      <= '0;
      pix_q      <= '0;
      scan_q     <= '0;
      row_q      <= '0;
      armed_q    <= 1'b0;
      s1_act_q   <= 1'b0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_scan_q  <= '0;
      s1_pix_q   <= '0;
      s2_act_q   <= 1'b0;
      s2_hs_q    <= 1'b0;
      s2_vs_q    <= 1'b0;
      s2_pix_q   <= '0;
      s2_inv_q   <= 1'b0;
      out_active <= 1'b0;
      out_h_sync <= 1'b0;
      out_v_sync <= 1'b0;
      out_rgb    <= '0;
    end else begin
      col_q      <= col_d;
      pix_q      <= pix_d;
      scan_q     <= scan_d;
      row_q      <= row_d;
      armed_q    <= armed_q | h_start;
      s1_act_q   <= line_act;
      s1_hs_q    <= h_sync;
      s1_vs_q    <= v_sync;
      s1_scan_q  <= scan_d;
      s1_pix_q   <= pix_cur;
      s2_act_q   <= s1_act_q;
      s2_hs_q    <= s1_hs_q;
      s2_vs_q    <= s1_vs_q;
      s2_pix_q   <= s1_pix_q;
      s2_inv_q   <= char_data[7];
      out_active <= s2_act_q;
      out_h_sync <= s2_hs_q;
      out_v_sync <= s2_vs_q;
      out_rgb    <= s2_act_q ? (pixel_on ? FG_RGB : BG_RGB) : 24'h000000;
    end
  end

endmodule

// File: tb/tb_hdmi_text_pixels.sv
// Self-checking bench for hdmi_text_pixels: behavioural char RAM / font ROM,
// a reference raster model feeding an expected-output queue, and a negedge
// monitor that pops and compares each output cycle.
`timescale 1ns/1ps
module tb_hdmi_text_pixels;

  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;

  logic        clk = 1'b0;
  logic        reset_low = 1'b1;
  logic        active = 1'b0, h_sync = 1'b0, v_sync = 1'b0;
  logic        h_start = 1'b0, v_start = 1'b0;
  logic [12:0] char_addr;
  logic [7:0]  char_data = 8'h00;
  logic [10:0] font_addr;
  logic [7:0]  font_data = 8'h00;
  logic        out_active, out_h_sync, out_v_sync;
  logic [23:0] out_rgb;
`ifdef HDMI_TEXT_CURSOR_EN
  logic [6:0]  cursor_col = 7'd0;
  logic [5:0]  cursor_row = 6'd63;
`endif

  hdmi_text_pixels dut (
    .clk        (clk),
    .reset_low  (reset_low),
    .active     (active),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .h_start    (h_start),
    .v_start    (v_start),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
`ifdef HDMI_TEXT_CURSOR_EN
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
`endif
    .out_active (out_active),
    .out_h_sync (out_h_sync),
    .out_v_sync (out_v_sync),
    .out_rgb    (out_rgb)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Memory contents: a fixed value pair or a position-dependent pattern.
  logic       fixed_mode = 1'b0;
  logic [7:0] fixed_char = 8'h00;
  logic [7:0] fixed_font = 8'h00;

  function automatic logic [7:0] char_val(input logic [5:0] r, input logic [6:0] c);
    if (fixed_mode) return fixed_char;
    return 8'(r * 7 + c * 13) ^ {c[1] ^ r[0], 7'd0};
  endfunction

  function automatic logic [7:0] font_val(input logic [6:0] code, input logic [3:0] scan);
    if (fixed_mode) return fixed_font;
    return 8'(code * 37 + scan * 11) ^ 8'h5A;
  endfunction

  // One-cycle-latency synchronous memories
  always @(posedge clk) begin
    char_data <= char_val(char_addr[12:7], char_addr[6:0]);
    font_data <= font_val(font_addr[10:4], font_addr[3:0]);
  end

  typedef struct {
    int unsigned due;
    logic        act;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_mon;

  // Raster model state
  int   m_line  = 0;
  int   m_x     = 0;
  logic m_armed = 1'b0;
  int   m_frame = -1;

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e_mon = sb_q.pop_front();
      checks++;
      if (e_mon.due != cyc || out_active !== e_mon.act || out_h_sync !== e_mon.hs ||
          out_v_sync !== e_mon.vs || out_rgb !== e_mon.rgb) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d due=%0d got act=%b hs=%b vs=%b rgb=%h exp act=%b hs=%b vs=%b rgb=%h",
                 cyc, e_mon.due, out_active, out_h_sync, out_v_sync, out_rgb,
                 e_mon.act, e_mon.hs, e_mon.vs, e_mon.rgb);
      end
    end
  end

  // Drive one cycle of timing and push the output expected 3 cycles later.
  task automatic drive(input logic act, input logic hs, input logic vs,
                       input logic hst, input logic vst);
    exp_t e;
    int row, col, scan, pix;
    logic [7:0] ch, ft;
    logic bit_on;
    @(posedge clk); #1;
    active = act; h_sync = hs; v_sync = vs; h_start = hst; v_start = vst;
    if (vst) begin
      m_line = 0;
      m_frame++;
    end else if (hst) begin
      m_line++;
    end
    if (hst) begin
      m_x = 0;
      m_armed = 1'b1;
    end
    e.due = cyc + 3;
    e.act = act & m_armed;
    e.hs  = hs;
    e.vs  = vs;
    e.rgb = 24'h000000;
    if (e.act) begin
      scan = m_line % 15;
      row  = m_line / 15;
      if (row > 39) row = 39;
      col  = m_x / 8;
      if (col > 127) col = 127;
      pix  = m_x % 8;
      ch = char_val(6'(row), 7'(col));
      ft = font_val(ch[6:0], 4'(scan));
      bit_on = ft[7 - pix] ^ ch[7];
`ifdef HDMI_TEXT_CURSOR_EN
      if (col == int'(cursor_col) && row == int'(cursor_row) && m_frame[4] == 1'b0)
        bit_on = ~bit_on;
`endif
      e.rgb = bit_on ? FG : BG;
      m_x++;
    end
    sb_q.push_back(e);
  endtask

  task automatic line(input logic vst, input int n_act, input int n_blank);
    drive(1'b1, 1'b0, vst, 1'b1, vst);
    for (int i = 1; i < n_act; i++) drive(1'b1, 1'b0, vst, 1'b0, 1'b0);
    for (int i = 0; i < n_blank; i++) drive(1'b0, 1'b1, vst, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8 && sb_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_low = 1'b0;
    active = 1'b0; h_sync = 1'b0; v_sync = 1'b0; h_start = 1'b0; v_start = 1'b0;
    sb_q.delete();
    m_line = 0; m_x = 0; m_armed = 1'b0; m_frame = -1;
    repeat (2) @(negedge clk);
    reset_low = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    active = 1'b1;
    reset_low = 1'b0;
    #1;
    checks++;
    if (out_active !== 1'b0) begin errors++; $display("FAIL reset_out_active got=%b exp=0", out_active); end
    checks++;
    if ({out_h_sync, out_v_sync} !== 2'b00) begin
      errors++; $display("FAIL reset_syncs got=%b exp=00", {out_h_sync, out_v_sync});
    end
    checks++;
    if (out_rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb got=%h exp=000000", out_rgb); end
    checks++;
    if (char_addr !== 13'h0) begin errors++; $display("FAIL reset_char_addr got=%h exp=0000", char_addr); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (font_addr !== 11'h0) begin errors++; $display("FAIL reset_font_addr got=%h exp=000", font_addr); end
    active = 1'b0;
    @(negedge clk);
    reset_low = 1'b1;
  endtask

  // First frame after reset: address 0 on the v_start cycle, 3-cycle latency.
  task automatic test_first_line();
    apply_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    checks++;
    if (char_addr !== 13'h0000) begin
      errors++; $display("FAIL first_char_addr got=%h exp=0000", char_addr);
    end
    for (int i = 1; i < 32; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    line(1'b0, 24, 3);
    drain();
  endtask

  task automatic test_pattern();
    fixed_mode = 1'b1;
    fixed_char = 8'h41;
    fixed_font = 8'b1000_0001;
    line(1'b1, 16, 4);
    drain();
    fixed_char = 8'hC1;
    line(1'b1, 16, 4);
    drain();
    fixed_mode = 1'b0;
  endtask

  // Row/scanline stepping, row 1 at line 16, and row saturation.
  task automatic test_rows();
    line(1'b1, 9, 2);
    for (int l = 1; l < 620; l++) begin
      if (l == 15 || l == 605) begin
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (l == 15 && char_addr !== 13'h0080) begin
          errors++; $display("FAIL row1_char_addr got=%h exp=0080", char_addr);
        end
        if (l == 605 && char_addr !== 13'h1380) begin
          errors++; $display("FAIL row_sat_char_addr got=%h exp=1380", char_addr);
        end
        for (int i = 1; i < 9; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
        line(1'b0, 9, 2);
      end
    end
    drain();
  endtask

  task automatic test_columns();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 1040; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 1030) begin
        #1;
        checks++;
        if (char_addr !== 13'h007F) begin
          errors++; $display("FAIL col_sat_char_addr got=%h exp=007F", char_addr);
        end
      end
    end
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    line(1'b1, 16, 0);
    line(1'b0, 16, 0);
    line(1'b0, 16, 0);
    drain();
  endtask

  task automatic test_reset_midline();
    line(1'b1, 16, 2);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_low = 1'b0;
    #1;
    checks++;
    if ({out_active, out_h_sync, out_v_sync} !== 3'b000 || out_rgb !== 24'h0 ||
        char_addr !== 13'h0 || font_addr !== 11'h0) begin
      errors++;
      $display("FAIL midline_reset got act=%b hs=%b vs=%b rgb=%h ca=%h fa=%h exp all 0",
               out_active, out_h_sync, out_v_sync, out_rgb, char_addr, font_addr);
    end
    sb_q.delete();
    m_line = 0; m_x = 0; m_armed = 1'b0;
    @(negedge clk);
    reset_low = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    line(1'b0, 16, 2);
    line(1'b1, 16, 2);
    drain();
  endtask

`ifdef HDMI_TEXT_CURSOR_EN
  task automatic test_cursor();
    apply_reset();
    fixed_mode = 1'b1;
    fixed_char = 8'h00;
    fixed_font = 8'h00;
    cursor_col = 7'd2;
    cursor_row = 6'd0;
    for (int f = 0; f < 17; f++) line(1'b1, 24, 2);
    drain();
    cursor_row = 6'd63;
    fixed_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_first_line();
    test_pattern();
    test_back_to_back();
    test_rows();
    test_columns();
    test_reset_midline();
`ifdef HDMI_TEXT_CURSOR_EN
    test_cursor();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t limit=2000000", $time);
    $fatal(1);
  end

endmodule
